reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 127 ++++++++++++
 tb/tb_reg_file_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file with NUM_RD combinational read ports, one writeback port and a
// per-register pending-write scoreboard. Optional write-to-read forwarding: REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    output logic                    iss_ready,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    flush,
    output logic [CW-1:0]           busy_cnt
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CW-1:0]    busy_cnt_q;
    logic [CW-1:0]    busy_cnt_d;
    logic             iss_ready_s;

    // Issue handshake: a WAW hazard stalls unless the pending write retires this cycle.
    always_comb begin
        iss_ready_s = 1'b0;
        if (flush) begin
            iss_ready_s = 1'b0;
        end else if ((iss_addr == '0) || !busy_q[iss_addr] ||
                     (wb_valid && (wb_addr == iss_addr))) begin
            iss_ready_s = 1'b1;
        end else begin
            iss_ready_s = 1'b0;
        end
    end

    // Next register contents; x0 is forced to zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end else begin
            regs_d[wb_addr] = regs_q[wb_addr];
        end
        regs_d[0] = '0;
    end

    // Next busy vector: writeback clears before issue sets, so same-address issue wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_valid) begin
                busy_d[wb_addr] = 1'b0;
            end else begin
                busy_d[wb_addr] = busy_q[wb_addr];
            end
            if (iss_valid && iss_ready_s) begin
                busy_d[iss_addr] = 1'b1;
            end else begin
                busy_d[iss_addr] = busy_d[iss_addr];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy count tracks the popcount of the next busy vector.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*WIDTH +: WIDTH] = regs_q[rd_addr[i*AW +: AW]];
                rd_busy[i]                = busy_q[rd_addr[i*AW +: AW]];
`ifdef REG_FILE_SB_BYPASS_EN
                // Forward the retiring value; rst_n gate keeps reads at zero while in reset.
                if (rst_n && wb_valid && (wb_addr == rd_addr[i*AW +: AW])) begin
                    rd_data[i*WIDTH +: WIDTH] = wb_data;
                    rd_busy[i]                = 1'b0;
                end else begin
                    rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
                end
`endif
            end else begin
                rd_data[i*WIDTH +: WIDTH] = '0;
                rd_busy[i]                = 1'b0;
            end
        end
    end

    assign iss_ready = iss_ready_s;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected values, a negedge monitor
// pops and compares them. Honours REG_FILE_SB_BYPASS_EN for the forwarding case.
module tb_reg_file_sb;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int CW = 6;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_CNT   = 2;
    localparam int K_READY = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_addr = '0;
    logic            iss_ready;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_addr = '0;
    logic [W-1:0]    wb_data = '0;
    logic            flush = 1'b0;
    logic [CW-1:0]   busy_cnt;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc_cnt    = 0;
    int   vectors    = 0;
    int   miscompares = 0;

    reg_file_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            K_DATA:  return rd_data[port*W +: W];
            K_BUSY:  return {31'd0, rd_busy[port]};
            K_CNT:   return {26'd0, busy_cnt};
            K_READY: return {31'd0, iss_ready};
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            chk_t c;
            logic [31:0] a;
            c = sb.pop_front();
            a = actual(c.kind, c.port);
            vectors++;
            if (c.cyc != cyc_cnt || a !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, due %0d)",
                         c.name, a, c.exp, cyc_cnt, c.cyc);
            end
        end
    end

    task automatic expect_v(input int kind, input int port, input logic [31:0] v,
                            input string nm);
        chk_t c;
        c.cyc = cyc_cnt; c.kind = kind; c.port = port; c.exp = v; c.name = nm;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_valid = 1'b1; iss_addr = a;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [W-1:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        // Power-on reset.
        step();
        expect_v(K_CNT, 0, 32'd0, "por_cnt");
        expect_v(K_READY, 0, 32'd1, "por_ready");
        expect_v(K_BUSY, 0, 32'd0, "por_busy0");
        step();
        rst_n = 1'b1;

        // Write x5, issue x6, then reset mid-run.
        wb(5'd5, 32'hDEAD_BEEF); issue(5'd6);
        step();
        idle(); rd(5'd5, 5'd6);
        expect_v(K_DATA, 0, 32'hDEAD_BEEF, "pre_rst_x5");
        expect_v(K_BUSY, 1, 32'd1, "pre_rst_x6_busy");
        expect_v(K_CNT, 0, 32'd1, "pre_rst_cnt");
        step();
        #1 rst_n = 1'b0;
        iss_addr = 5'd6;
        expect_v(K_DATA, 0, 32'h0, "rst_x5");
        expect_v(K_BUSY, 0, 32'd0, "rst_busy0");
        expect_v(K_BUSY, 1, 32'd0, "rst_busy1");
        expect_v(K_CNT, 0, 32'd0, "rst_cnt");
        expect_v(K_READY, 0, 32'd1, "rst_ready");
        step();
        rst_n = 1'b1;

        // x0 protection.
        wb(5'd0, 32'hFFFF_FFFF); issue(5'd0); rd(5'd0, 5'd0);
        expect_v(K_READY, 0, 32'd1, "x0_ready");
        expect_v(K_DATA, 0, 32'h0, "x0_data_wb");
        step();
        idle();
        expect_v(K_DATA, 0, 32'h0, "x0_data0");
        expect_v(K_DATA, 1, 32'h0, "x0_data1");
        expect_v(K_BUSY, 0, 32'd0, "x0_busy");
        expect_v(K_CNT, 0, 32'd0, "x0_cnt");

        // Scoreboard cycle on x7.
        step();
        issue(5'd7);
        expect_v(K_READY, 0, 32'd1, "x7_ready1");
        step();
        rd(5'd0, 5'd7);
        expect_v(K_BUSY, 1, 32'd1, "x7_busy");
        expect_v(K_CNT, 0, 32'd1, "x7_cnt1");
        expect_v(K_READY, 0, 32'd0, "x7_waw_stall");
        step();
        idle(); wb(5'd7, 32'h1234_5678);
`ifdef REG_FILE_SB_BYPASS_EN
        expect_v(K_DATA, 1, 32'h1234_5678, "x7_fwd_data");
        expect_v(K_BUSY, 1, 32'd0, "x7_fwd_busy");
`else
        expect_v(K_DATA, 1, 32'h0, "x7_old_data");
        expect_v(K_BUSY, 1, 32'd1, "x7_old_busy");
`endif
        step();
        idle(); rd(5'd7, 5'd7);
        expect_v(K_DATA, 0, 32'h1234_5678, "x7_data0");
        expect_v(K_DATA, 1, 32'h1234_5678, "x7_data1");
        expect_v(K_BUSY, 1, 32'd0, "x7_busy_clr");
        expect_v(K_CNT, 0, 32'd0, "x7_cnt0");

        // Simultaneous issue and writeback on x3.
        step();
        issue(5'd3);
        step();
        wb(5'd3, 32'h0000_00A5); issue(5'd3);
        expect_v(K_READY, 0, 32'd1, "x3_same_ready");
        step();
        idle(); rd(5'd3, 5'd0);
        expect_v(K_DATA, 0, 32'h0000_00A5, "x3_data");
        expect_v(K_BUSY, 0, 32'd1, "x3_busy");
        expect_v(K_CNT, 0, 32'd1, "x3_cnt");

        // Flush with x1, x2, x3 busy.
        issue(5'd1);
        step();
        issue(5'd2);
        step();
        flush = 1'b1; issue(5'd4);
        expect_v(K_CNT, 0, 32'd3, "fl_cnt3");
        expect_v(K_READY, 0, 32'd0, "fl_ready");
        step();
        idle(); rd(5'd4, 5'd3);
        expect_v(K_BUSY, 0, 32'd0, "fl_x4_busy");
        expect_v(K_BUSY, 1, 32'd0, "fl_x3_busy");
        expect_v(K_DATA, 1, 32'h0000_00A5, "fl_x3_data");
        expect_v(K_CNT, 0, 32'd0, "fl_cnt0");

        // Forwarding on x9 with x9 pending.
        step();
        wb(5'd9, 32'h1111_0000); issue(5'd9);
        step();
        idle(); wb(5'd9, 32'hCAFE_0001); rd(5'd0, 5'd9);
        expect_v(K_CNT, 0, 32'd1, "byp_cnt");
`ifdef REG_FILE_SB_BYPASS_EN
        expect_v(K_DATA, 1, 32'hCAFE_0001, "byp_data");
        expect_v(K_BUSY, 1, 32'd0, "byp_busy");
`else
        expect_v(K_DATA, 1, 32'h1111_0000, "byp_old_data");
        expect_v(K_BUSY, 1, 32'd1, "byp_old_busy");
`endif
        step();
        idle();
        expect_v(K_DATA, 1, 32'hCAFE_0001, "byp_next_data");
        expect_v(K_BUSY, 1, 32'd0, "byp_next_busy");
        expect_v(K_CNT, 0, 32'd0, "byp_next_cnt");

        // Set and clear on different addresses nets zero.
        step();
        issue(5'd10);
        step();
        wb(5'd10, 32'h0000_0010); issue(5'd11);
        expect_v(K_READY, 0, 32'd1, "net_ready");
        step();
        idle(); rd(5'd10, 5'd11);
        expect_v(K_CNT, 0, 32'd1, "net_cnt");
        expect_v(K_BUSY, 0, 32'd0, "net_x10_busy");
        expect_v(K_BUSY, 1, 32'd1, "net_x11_busy");
        expect_v(K_DATA, 0, 32'h0000_0010, "net_x10_data");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
